// File: rtl/punc_control_hs_if.sv
// Memory request/acknowledge port between the PUnC control FSM and memory.
// The controller drives the request side; memory returns mem_ack.
interface punc_control_hs_if;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_addr_sel;
    logic       mem_w_data_sel;
    logic       mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr_sel, mem_w_data_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr_sel, mem_w_data_sel,
        output mem_ack
    );
endinterface

// File: rtl/punc_control_hs.sv
// PUnC LC3 multi-cycle control FSM with a variable-latency req/ack memory
// port, two-access LDI/STI, memory-wait timeout with fault, halt/resume and
// a saturating retired-instruction counter.
module punc_control_hs #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    punc_control_hs_if.master        mem,
    input  logic [15:0]              ir,
    input  logic                     n,
    input  logic                     z,
    input  logic                     p,
    input  logic                     resume,
    output logic                     ind_ld,
    output logic                     rf_w_en,
    output logic                     rf_w_addr_sel,
    output logic [1:0]               rf_w_data_sel,
    output logic                     rf_r0_addr_sel,
    output logic                     rf_r1_addr_sel,
    output logic                     ir_ld,
    output logic                     pc_ld,
    output logic                     pc_clr,
    output logic                     pc_inc,
    output logic [1:0]               pc_ld_data_sel,
    output logic [2:0]               alu_sel,
    output logic                     cond_ld,
    output logic                     cond_ld_data_sel,
    output logic                     halted,
    output logic                     fault,
    output logic [CNT_W-1:0]         retired
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC, S_IND, S_HALT, S_FAULT
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              done;
    logic              req, we, ack;
    logic [1:0]        addr_sel;
    logic [3:0]        opcode;
    logic              br_taken;
    logic              unused_ir;

    assign ack      = mem.mem_ack;
    assign opcode   = ir[15:12];
    assign br_taken = (n & ir[11]) | (z & ir[10]) | (p & ir[9]);
    // Operand fields are decoded by the datapath, not here.
    assign unused_ir = ^{ir[8:6], ir[4:0]};

    assign mem.mem_req        = req;
    assign mem.mem_we         = we;
    assign mem.mem_addr_sel   = addr_sel;
    assign mem.mem_w_data_sel = 1'b0;
    assign rf_r1_addr_sel     = 1'b0;

    // State, wait counter and saturating retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (done && (retired != {CNT_W{1'b1}})) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Next-state and control decode; every output starts at 0.
    always_comb begin
        state_next       = state;
        done             = 1'b0;
        req              = 1'b0;
        we               = 1'b0;
        addr_sel         = 2'd0;
        ind_ld           = 1'b0;
        rf_w_en          = 1'b0;
        rf_w_addr_sel    = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_r0_addr_sel   = 1'b0;
        ir_ld            = 1'b0;
        pc_ld            = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;
        halted           = 1'b0;
        fault            = 1'b0;
        // pc_clr is held off while rst is asserted so it pulses only after release.
        pc_clr           = 1'b0;

        case (state)
            S_INIT: begin
                pc_clr     = ~rst;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                req = 1'b1;
                if (ack) begin
                    ir_ld      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_inc     = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                done       = 1'b1;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_w_en = 1'b1;
                        cond_ld = 1'b1;
                        if (opcode == OP_NOT)      alu_sel = 3'd4;
                        else if (opcode == OP_AND) alu_sel = ir[5] ? 3'd3 : 3'd2;
                        else                       alu_sel = ir[5] ? 3'd1 : 3'd0;
                    end
                    OP_BR: begin
                        pc_ld = br_taken;
                    end
                    OP_JMP: begin
                        pc_ld          = 1'b1;
                        pc_ld_data_sel = 2'd1;
                    end
                    OP_JSR: begin
                        rf_w_en        = 1'b1;
                        rf_w_addr_sel  = 1'b1;
                        rf_w_data_sel  = 2'd2;
                        pc_ld          = 1'b1;
                        pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                    end
                    OP_LEA: begin
                        rf_w_en          = 1'b1;
                        rf_w_data_sel    = 2'd3;
                        cond_ld          = 1'b1;
                        cond_ld_data_sel = 1'b1;
                    end
                    OP_LD, OP_LDR: begin
                        req        = 1'b1;
                        addr_sel   = (opcode == OP_LD) ? 2'd1 : 2'd2;
                        done       = ack;
                        state_next = ack ? S_FETCH : S_EXEC;
                        if (ack) begin
                            rf_w_en          = 1'b1;
                            rf_w_data_sel    = 2'd1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                    end
                    OP_ST, OP_STR: begin
                        req            = 1'b1;
                        we             = 1'b1;
                        rf_r0_addr_sel = 1'b1;
                        addr_sel       = (opcode == OP_ST) ? 2'd1 : 2'd2;
                        done           = ack;
                        state_next     = ack ? S_FETCH : S_EXEC;
                    end
                    OP_LDI, OP_STI: begin
                        // First access fetches the pointer; the data access happens in IND.
                        req        = 1'b1;
                        addr_sel   = 2'd1;
                        done       = 1'b0;
                        ind_ld     = ack;
                        state_next = ack ? S_IND : S_EXEC;
                    end
                    OP_HLT: begin
                        state_next = S_HALT;
                    end
                    default: begin
                    end
                endcase
            end
            S_IND: begin
                req        = 1'b1;
                addr_sel   = 2'd3;
                done       = ack;
                state_next = ack ? S_FETCH : S_IND;
                if (opcode == OP_STI) begin
                    we             = 1'b1;
                    rf_r0_addr_sel = 1'b1;
                end else if (ack) begin
                    rf_w_en          = 1'b1;
                    rf_w_data_sel    = 2'd1;
                    cond_ld          = 1'b1;
                    cond_ld_data_sel = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) state_next = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase

        // An access that has waited TIMEOUT cycles and still sees no ack faults.
        if ((TIMEOUT != 0) && req && !ack && (wait_cnt == WAIT_MAX)) begin
            state_next = S_FAULT;
        end

        wait_next = (req && !ack) ? wait_cnt + WAIT_W'(1) : '0;
    end

endmodule
